// File: rtl/proc9_pkg.sv
// Shared types and constants for the 9-bit processor control path.
package proc9_pkg;

    localparam int unsigned IR_W    = 9;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned NREGS   = 8;

    // IR field slices: opcode | X | Y
    localparam int unsigned OP_MSB = 8;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned X_MSB  = 5;
    localparam int unsigned X_LSB  = 3;
    localparam int unsigned Y_MSB  = 2;
    localparam int unsigned Y_LSB  = 0;

    localparam logic [FIELD_W-1:0] OP_MV  = 3'b000;
    localparam logic [FIELD_W-1:0] OP_MVI = 3'b001;
    localparam logic [FIELD_W-1:0] OP_ADD = 3'b010;
    localparam logic [FIELD_W-1:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

endpackage

// File: rtl/proc9_control_unit_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8
    import proc9_pkg::*;
(
    input  logic [FIELD_W-1:0] sel,
    input  logic               en,
    output logic [NREGS-1:0]   dec_c
);

    always_comb begin
        dec_c = '0;
        if (en) begin
            dec_c[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc9_control_unit.sv
// Instruction sequencer: IR latch plus T0..T3 step FSM decoding datapath controls.
module proc9_control_unit
    import proc9_pkg::*;
#(
    parameter int unsigned DATA_W = 9
) (
    input  logic              clock,
    input  logic              aResetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [NREGS-1:0]  Rin,
    output logic [NREGS-1:0]  Rout,
    output logic              DINout,
    output logic              Gout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done,
    output logic [1:0]        Tstep_Q
);

    tstep_t             state;
    tstep_t             state_next;
    logic [IR_W-1:0]    ir;
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] rx;
    logic [FIELD_W-1:0] ry;
    logic [NREGS-1:0]   x_oh;
    logic [NREGS-1:0]   y_oh;

    assign op = ir[OP_MSB:OP_LSB];
    assign rx = ir[X_MSB:X_LSB];
    assign ry = ir[Y_MSB:Y_LSB];

    // X is used in T1 and T3, Y only in T1 and T2; idle decoders stay quiet
    dec3to8 u_dec_x (
        .sel   (rx),
        .en    (state != T0),
        .dec_c (x_oh)
    );

    dec3to8 u_dec_y (
        .sel   (ry),
        .en    ((state == T1) || (state == T2)),
        .dec_c (y_oh)
    );

    always_ff @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            state <= T0;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            ir <= '0;
        end else if (IRin) begin
            ir <= IR_W'(DIN);
        end
    end

    // Next-step and control decode from (state, IR); IRin also follows Run
    always_comb begin
        state_next = state;
        IRin       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        DINout     = 1'b0;
        Gout       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        Done       = 1'b0;
        case (state)
            T0: begin
                IRin = Run;
                if (Run) begin
                    state_next = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        Rout       = y_oh;
                        Rin        = x_oh;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_MVI: begin
                        DINout     = 1'b1;
                        Rin        = x_oh;
                        Done       = 1'b1;
                        state_next = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout       = x_oh;
                        Ain        = 1'b1;
                        state_next = T2;
                    end
                    default: begin
                        Done       = 1'b1;
                        state_next = T0;
                    end
                endcase
            end
            T2: begin
                Rout       = y_oh;
                Gin        = 1'b1;
                AddSub     = op[0];
                state_next = T3;
            end
            T3: begin
                Gout       = 1'b1;
                Rin        = x_oh;
                Done       = 1'b1;
                state_next = T0;
            end
            default: begin
                state_next = T0;
            end
        endcase
    end

    assign Tstep_Q = state;

endmodule

// File: tb/tb_proc9_control_unit.sv
// Self-checking bench: per-instruction expected-output scoreboard plus directed literal checks.
module tb_proc9_control_unit;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       dinout;
        logic       gout;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       done;
        logic [1:0] tstep;
    } obs_t;

    logic       clock = 1'b0;
    logic       aResetn;
    logic       Run;
    logic [8:0] DIN;
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       DINout;
    logic       Gout;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;
    logic [1:0] Tstep_Q;

    int   total = 0;
    int   bad   = 0;
    obs_t pend[$];
    obs_t snap;

    always #5 clock = ~clock;

    proc9_control_unit #(.DATA_W(9)) dut (
        .clock   (clock),
        .aResetn (aResetn),
        .Run     (Run),
        .DIN     (DIN),
        .IRin    (IRin),
        .Rin     (Rin),
        .Rout    (Rout),
        .DINout  (DINout),
        .Gout    (Gout),
        .Ain     (Ain),
        .Gin     (Gin),
        .AddSub  (AddSub),
        .Done    (Done),
        .Tstep_Q (Tstep_Q)
    );

    // Expected per-cycle outputs for the steps after an accepted instruction word
    task automatic expand(input logic [8:0] w);
        obs_t       s;
        logic [7:0] xo;
        logic [7:0] yo;
        xo = 8'(1) << w[5:3];
        yo = 8'(1) << w[2:0];
        case (w[8:6])
            3'd0: begin
                s = '0; s.rout = yo; s.rin = xo; s.done = 1'b1; s.tstep = 2'd1;
                pend.push_back(s);
            end
            3'd1: begin
                s = '0; s.dinout = 1'b1; s.rin = xo; s.done = 1'b1; s.tstep = 2'd1;
                pend.push_back(s);
            end
            3'd2, 3'd3: begin
                s = '0; s.rout = xo; s.ain = 1'b1; s.tstep = 2'd1;
                pend.push_back(s);
                s = '0; s.rout = yo; s.gin = 1'b1; s.addsub = w[6]; s.tstep = 2'd2;
                pend.push_back(s);
                s = '0; s.gout = 1'b1; s.rin = xo; s.done = 1'b1; s.tstep = 2'd3;
                pend.push_back(s);
            end
            default: begin
                s = '0; s.done = 1'b1; s.tstep = 2'd1;
                pend.push_back(s);
            end
        endcase
    endtask

    // Reference sequencer: idle accepts on Run, busy steps through its queue
    always @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            pend.delete();
        end else if (pend.size() == 0) begin
            if (Run) expand(DIN);
        end else begin
            void'(pend.pop_front());
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Apply inputs, compare against the model at negedge, return just after next posedge
    task automatic drive(input logic rst, input logic run, input logic [8:0] din);
        obs_t e;
        aResetn = rst;
        Run     = run;
        DIN     = din;
        @(negedge clock);
        snap = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Tstep_Q};
        if (pend.size() > 0) begin
            e = pend[0];
        end else begin
            e = '0;
            e.irin = Run;
        end
        total++;
        if (snap !== e) begin
            bad++;
            $display("FAIL model got=%h exp=%h t=%0t", snap, e, $time);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        aResetn = 1'b0;
        Run     = 1'b0;
        DIN     = '0;
        repeat (2) @(posedge clock);
        #1;

        // reset state, IRin follows Run even in reset
        drive(1'b0, 1'b0, 9'h1ff);
        chk("rst_all", 8'(snap), 8'h00);
        chk("rst_rin", snap.rin, 8'h00);
        drive(1'b0, 1'b1, 9'h0);
        chk("rst_irin", 8'(snap.irin), 8'h01);
        chk("rst_tstep", 8'(snap.tstep), 8'h00);

        // mv R3,R5
        drive(1'b1, 1'b1, 9'b000_011_101);
        chk("mv_t0_irin", 8'(snap.irin), 8'h01);
        drive(1'b1, 1'b0, 9'h0);
        chk("mv_rout", snap.rout, 8'h20);
        chk("mv_rin", snap.rin, 8'h08);
        chk("mv_done", 8'(snap.done), 8'h01);
        drive(1'b1, 1'b0, 9'h0);
        chk("mv_back_t0", 8'(snap.tstep), 8'h00);

        // mvi R2,#D
        drive(1'b1, 1'b1, 9'b001_010_000);
        drive(1'b1, 1'b0, 9'h155);
        chk("mvi_dinout", 8'(snap.dinout), 8'h01);
        chk("mvi_rin", snap.rin, 8'h04);
        chk("mvi_rout_gout", {snap.rout[6:0], snap.gout}, 8'h00);

        // add R1,R6
        drive(1'b1, 1'b1, 9'b010_001_110);
        drive(1'b1, 1'b0, 9'h0);
        chk("add_t1_rout", snap.rout, 8'h02);
        chk("add_t1_ain", 8'(snap.ain), 8'h01);
        drive(1'b1, 1'b0, 9'h0);
        chk("add_t2_rout", snap.rout, 8'h40);
        chk("add_t2_gin_as", {6'd0, snap.gin, snap.addsub}, 8'h02);
        drive(1'b1, 1'b0, 9'h0);
        chk("add_t3_rin", snap.rin, 8'h02);
        chk("add_t3_gout_done", {6'd0, snap.gout, snap.done}, 8'h03);

        // sub R7,R0
        drive(1'b1, 1'b1, 9'b011_111_000);
        drive(1'b1, 1'b0, 9'h0);
        drive(1'b1, 1'b0, 9'h0);
        chk("sub_t2_addsub", 8'(snap.addsub), 8'h01);
        chk("sub_t2_rout", snap.rout, 8'h01);
        drive(1'b1, 1'b0, 9'h0);
        chk("sub_t3_rin", snap.rin, 8'h80);

        // back-to-back mv then add with Run high, Run dropped in T2
        drive(1'b1, 1'b1, 9'b000_000_001);
        drive(1'b1, 1'b1, 9'b010_010_011);
        chk("b2b_mv_done", 8'(snap.done), 8'h01);
        drive(1'b1, 1'b1, 9'b010_010_011);
        chk("b2b_irin", {6'd0, snap.irin, snap.tstep[0]}, 8'h02);
        drive(1'b1, 1'b1, 9'h0);
        drive(1'b1, 1'b0, 9'h0);
        chk("b2b_t2", 8'(snap.tstep), 8'h02);
        drive(1'b1, 1'b0, 9'h0);
        chk("b2b_t3_done", {6'd0, snap.done, snap.gout}, 8'h03);
        drive(1'b1, 1'b0, 9'h0);

        // reset asserted mid-T2 of an add
        drive(1'b1, 1'b1, 9'b010_000_001);
        drive(1'b1, 1'b0, 9'h0);
        #2;
        aResetn = 1'b0;
        #1;
        chk("midrst_tstep", 8'(Tstep_Q), 8'h00);
        chk("midrst_rout", Rout, 8'h00);
        chk("midrst_ctl", {2'd0, IRin, Gin, Ain, Gout, Done, AddSub}, 8'h00);
        @(posedge clock);
        #1;
        drive(1'b0, 1'b0, 9'h0);
        drive(1'b1, 1'b1, 9'b111_000_000);
        drive(1'b1, 1'b0, 9'h0);
        chk("nop_done", 8'(snap.done), 8'h01);
        chk("nop_enables", snap.rin | snap.rout, 8'h00);
        chk("nop_ctl", {3'd0, snap.dinout, snap.gout, snap.ain, snap.gin, snap.addsub}, 8'h00);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic       rst;
            logic       run;
            logic [8:0] din;
            rst = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            run = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            din = 9'($urandom);
            drive(rst, run, din);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
